bayer_mosaic: RTL and testbench
===============================

# bayer_mosaic

Reads a full-colour image from the three R/G/B image memories and streams it out as a single-channel Bayer mosaic, one 8-bit pixel per accepted beat, in raster order. It is the inverse of the demosaic path: it produces the Bayer input stream the demosaic block consumes, and is used for regression and round-trip checks. Output uses a valid/ready handshake with full back-pressure support.

## Interface
- IMG_W_LOG2, 7: log2 of image width in pixels (128).
- IMG_H_LOG2, 7: log2 of image height in pixels (128); address width AW = IMG_W_LOG2 + IMG_H_LOG2 (14).
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE or DONE.
- addr_r  output  AW  R memory read address.
- rdata_r  input  8  R memory read data, combinational from addr_r in the same cycle.
- addr_g  output  AW  G memory read address.
- rdata_g  input  8  G memory read data, same-cycle.
- addr_b  output  AW  B memory read address.
- rdata_b  input  8  B memory read data, same-cycle.
- data_out  output  8  mosaic pixel.
- out_valid  output  1  data_out/out_last valid.
- out_ready  input  1  downstream accepts the beat when high with out_valid.
- out_last  output  1  high with the final pixel of the frame.
- done  output  1  level; high in DONE state.

## Operation
- Pixel counter cnt (AW bits): x = cnt[IMG_W_LOG2-1:0], y = cnt[AW-1:IMG_W_LOG2]. All three addr_* equal cnt in RUN; 0 in IDLE, DRAIN and DONE.
- Channel select: y even, x even → G; y even, x odd → R; y odd, x even → B; y odd, x odd → G.
- FSM states:
  - IDLE → RUN on start, with cnt cleared to 0.
  - RUN: issue when !out_valid || out_ready. On issue, the selected rdata goes to data_out, out_valid is set to 1, and cnt increments. out_last is set to 1 when cnt == 2^AW−1. Issuing the last pixel moves the FSM to DRAIN without a cnt wrap. When the stall condition holds (out_valid && !out_ready), cnt, addr_*, data_out and out_last hold.
  - DRAIN: on out_ready, out_valid → 0, out_last → 0, and the FSM moves to DONE.
  - DONE: done = 1. start → RUN, with cnt = 0 and done falling.
- start is ignored in RUN and DRAIN.
- Reset values:
  - State: IDLE.
  - Outputs: cnt = 0, data_out = 0, out_valid = 0, out_last = 0, done = 0, addr_* = 0.
- Asserting reset mid-frame aborts immediately to these values; no partial beat survives.
- No arithmetic on pixel data; values pass unchanged.

## Timing
- Throughput 1 pixel/cycle when out_ready stays high.
- Latency: start sampled at edge of cycle 0; RUN in cycle 1 with addr = 0. Pixel k is visible on data_out in cycle k+2.
- With out_ready constant 1:
  - Last pixel visible in cycle 2^AW+1 (16385).
  - done rises in cycle 2^AW+2 (16386).
- A beat transfers on a cycle where out_valid && out_ready. data_out must not change while out_valid && !out_ready.
- When out_ready is low in the cycle a beat is issued, that beat is not lost.

## Configuration
- MOSAIC_CHECKSUM_EN defined:
  - Adds output checksum [15:0], reset to 0 and cleared when a frame starts.
  - Adds data_out zero-extended on every transferred beat, modulo 2^16.
  - Valid when done is high.
- Undefined: the checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- Constant memories R=0x11, G=0x22, B=0x33, out_ready=1, start pulse → beats 0..3 = 22,11,22,11. Beat 128 = 33, beat 129 = 22. out_last only on beat 16383. done rises at cycle 16386. With the macro, checksum = 0x8000.
- Memory value = low byte of address in all three memories → beat k equals k[7:0] for all k. No gaps or duplicates across row boundaries 127→128.
- Drop out_ready for 5 cycles while beat 10 is valid → data_out stays at beat 10 value and addr_* stays at 11 for all 5 cycles. Beat 11 follows on the first cycle after out_ready returns. Total beat count is 16384.
- out_ready low when last pixel issued → FSM stays in DRAIN with out_valid=out_last=1. done rises the cycle after out_ready returns high.
- Assert reset at beat 5000 → next cycle out_valid=0, done=0, addr_*=0. A later start produces the frame from beat 0 with correct data.
- start pulses during RUN and DRAIN → ignored, frame unaffected. start in DONE → second identical frame; with the macro, checksum is re-cleared and ends at 0x8000 again.

Source files
------------

// File: rtl/bayer_mosaic.sv
// Streams the R/G/B image memories out as a single-channel Bayer mosaic (GRBG) in raster order.
// Optional MOSAIC_CHECKSUM_EN adds a 16-bit sum of all transferred beats on `checksum`.
module bayer_mosaic #(
    parameter int IMG_W_LOG2 = 7,
    parameter int IMG_H_LOG2 = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_r,
    input  logic [7:0]                       rdata_r,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_g,
    input  logic [7:0]                       rdata_g,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_b,
    input  logic [7:0]                       rdata_b,
    output logic [7:0]                       data_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             done
`ifdef MOSAIC_CHECKSUM_EN
    ,output logic [15:0]                     checksum
`endif
);
    localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_cnt;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_last;
    logic [7:0]    w_pix;
    logic          w_issue;
    logic          w_cnt_max;
    logic          w_go;

    assign w_cnt_max = &r_cnt;
    assign w_issue   = (r_state == S_RUN) && (!r_valid || out_ready);
    assign w_go      = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Parity of x and y picks the channel: equal parity is G, odd row is B, else R.
    always_comb begin
        w_pix = rdata_g;
        if (r_cnt[0] != r_cnt[IMG_W_LOG2]) begin
            if (r_cnt[IMG_W_LOG2])
                w_pix = rdata_b;
            else
                w_pix = rdata_r;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_RUN;
            S_RUN:          if (w_issue && w_cnt_max) w_next = S_DRAIN;
            S_DRAIN:        if (out_ready) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr_r = '0;
        addr_g = '0;
        addr_b = '0;
        done   = 1'b0;
        if (r_state == S_RUN) begin
            addr_r = r_cnt;
            addr_g = r_cnt;
            addr_b = r_cnt;
        end
        if (r_state == S_DONE)
            done = 1'b1;
    end

    // The last issue leaves cnt at its maximum; the next start clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_go) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_data  <= w_pix;
            r_valid <= 1'b1;
            r_last  <= w_cnt_max;
            if (!w_cnt_max)
                r_cnt <= r_cnt + AW'(1);
        end else if ((r_state == S_DRAIN) && out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;

`ifdef MOSAIC_CHECKSUM_EN
    logic [15:0] r_sum;
    logic        w_xfer;

    assign w_xfer = r_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_sum <= 16'h0000;
        else if (w_go)
            r_sum <= 16'h0000;
        else if (w_xfer)
            r_sum <= r_sum + {8'h00, r_data};
    end

    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed bench for bayer_mosaic: constant and address-pattern memories, back-pressure,
// DRAIN stall, mid-frame reset and start pulses outside IDLE/DONE.
module tb_bayer_mosaic;
    localparam int AW   = 14;
    localparam int NPIX = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr_r, addr_g, addr_b;
    logic [7:0]    rdata_r, rdata_g, rdata_b;
    logic [7:0]    data_out;
    logic          out_valid, out_ready, out_last, done;
`ifdef MOSAIC_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    bit            mode;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    logic [7:0]    got [NPIX];
    int            beats, bad, nlast, lastidx, last_cyc, done_cyc;
    int            hold_bad, drain_bad, f11_bad, c0;

    bayer_mosaic dut (
        .clk(clk), .reset(reset), .start(start),
        .addr_r(addr_r), .rdata_r(rdata_r),
        .addr_g(addr_g), .rdata_g(rdata_g),
        .addr_b(addr_b), .rdata_b(rdata_b),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
`ifdef MOSAIC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: constant per channel, or low byte of the address.
    assign rdata_r = mode ? addr_r[7:0] : 8'h11;
    assign rdata_g = mode ? addr_g[7:0] : 8'h22;
    assign rdata_b = mode ? addr_b[7:0] : 8'h33;

    function automatic logic [7:0] expv(input int k, input bit m);
        logic [AW-1:0] a;
        a = AW'(k);
        if (m) return a[7:0];
        if (a[0] == a[7]) return 8'h22;
        if (a[7]) return 8'h33;
        return 8'h11;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic run_frame(input bit m, input bit do_stall, input bit do_lstall, input int abort_at);
        int  guard;
        bit  stalled, lstalled, chk11, pulsed;
        logic [7:0] e;
        mode = m;
        beats = 0; bad = 0; nlast = 0; lastidx = -1; last_cyc = -1; done_cyc = -1;
        hold_bad = 0; drain_bad = 0; f11_bad = 0;
        stalled = 0; lstalled = 0; chk11 = 0; pulsed = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        check("first_cycle_addr", {addr_r, addr_g, addr_b}, '0);
        check("first_cycle_valid", out_valid, 1'b0);
        check("first_cycle_done", done, 1'b0);
        guard = 0;
        while (guard < 20000) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            if (chk11) begin
                chk11 = 0;
                if (!out_valid || data_out !== expv(11, m)) f11_bad++;
            end
            if (abort_at >= 0 && beats == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_last", out_last, 1'b0);
                check("abort_addr", {addr_r, addr_g, addr_b}, '0);
                check("abort_data", data_out, 8'h00);
`ifdef MOSAIC_CHECKSUM_EN
                check("abort_checksum", checksum, 16'h0000);
`endif
                reset = 1'b1;
                break;
            end
            if (done) begin
                done_cyc = cyc - c0 + 1;
                break;
            end
            if (beats == 100 && !pulsed) begin
                pulsed = 1;
                start = 1'b1;
            end
            if (do_stall && out_valid && beats == 10 && !stalled) begin
                stalled = 1;
                out_ready = 1'b0;
                e = expv(10, m);
                repeat (5) begin
                    @(negedge clk);
                    start = 1'b0;
                    if (data_out !== e || !out_valid || addr_r !== AW'(11) ||
                        addr_g !== AW'(11) || addr_b !== AW'(11)) hold_bad++;
                end
                out_ready = 1'b1;
                chk11 = 1;
            end
            if (do_lstall && out_valid && out_last && !lstalled) begin
                lstalled = 1;
                out_ready = 1'b0;
                start = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    start = 1'b0;
                    if (!out_valid || !out_last || done) drain_bad++;
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                e = expv(beats, m);
                if (beats < NPIX) got[beats] = data_out;
                if (data_out !== e) bad++;
                if (out_last) begin
                    nlast++;
                    lastidx = beats;
                    last_cyc = cyc - c0 + 1;
                end
                beats++;
            end
        end
        start = 1'b0;
    endtask

    task automatic full_frame_checks();
        check("beat_count", beats, NPIX);
        check("beat_data_errs", bad, 0);
        check("last_count", nlast, 1);
        check("last_index", lastidx, NPIX - 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b1; mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_addr", {addr_r, addr_g, addr_b}, '0);
`ifdef MOSAIC_CHECKSUM_EN
        check("rst_checksum", checksum, 16'h0000);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Frame A: constant memories, start pulse mid-RUN.
        run_frame(1'b0, 1'b0, 1'b0, -1);
        full_frame_checks();
        check("A_beat0", got[0], 8'h22);
        check("A_beat1", got[1], 8'h11);
        check("A_beat2", got[2], 8'h22);
        check("A_beat3", got[3], 8'h11);
        check("A_beat128", got[128], 8'h33);
        check("A_beat129", got[129], 8'h22);
        check("A_beat16383", got[16383], 8'h22);
        check("A_last_cycle", last_cyc, 16385);
        check("A_done_cycle", done_cyc, 16386);
`ifdef MOSAIC_CHECKSUM_EN
        check("A_checksum", checksum, 16'h8000);
`endif

        // Frame B from DONE: address pattern, stall at beat 10, stall in DRAIN with start.
        run_frame(1'b1, 1'b1, 1'b1, -1);
        full_frame_checks();
        check("B_beat127", got[127], 8'h7F);
        check("B_beat128", got[128], 8'h80);
        check("B_beat255", got[255], 8'hFF);
        check("B_beat256", got[256], 8'h00);
        check("B_stall_hold", hold_bad, 0);
        check("B_beat11_follow", f11_bad, 0);
        check("B_drain_hold", drain_bad, 0);
        check("B_done_after_ready", done_cyc, last_cyc + 1);
`ifdef MOSAIC_CHECKSUM_EN
        check("B_checksum", checksum, 16'hE000);
`endif

        // Frame C: reset asserted while beat 5000 is on the output.
        run_frame(1'b0, 1'b0, 1'b0, 5000);
        check("C_beats_before_abort", beats, 5000);
        check("C_data_errs", bad, 0);
        @(negedge clk);
        check("C_idle_valid", out_valid, 1'b0);

        // Frame D from IDLE after the abort.
        run_frame(1'b0, 1'b0, 1'b0, -1);
        full_frame_checks();
        check("D_beat0", got[0], 8'h22);
        check("D_done_cycle", done_cyc, 16386);
`ifdef MOSAIC_CHECKSUM_EN
        check("D_checksum", checksum, 16'h8000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
